// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte indexing, ShiftRows and the
// S-box. These helpers are reused by the key expansion block.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = AES_STATE_W / 8;

  // Column-major state: byte s(r,c) lives at bits [8*(4c+r) +: 8], byte 0 first.
  typedef logic [0:AES_STATE_W-1] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_DONE
  } sub_shift_st_e;

  // Byte position of s(r,c) in the column-major state.
  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  // ShiftRows: row r rotates left by r, so out s(r,c) = in s(r,(c+r) mod 4).
  // Pure wiring once the loops unroll.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[8*byte_idx(r, c) +: 8] = s[8*byte_idx(r, (c + r) % 4) +: 8];
      end
    end
    return res;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product, shift-and-add over the bits of b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, which the S-box requires).
  // Addition chain: 2, 3, 6, 12, 15, 30, 60, 120, 240, 252, 254.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(a3, a3);
    a12  = gf_mul(a12, a12);
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  // FIPS-197 S-box: inversion followed by the affine transform with 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES S-box lane, shared with the key expansion block.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  assign subst = sbox(plain);

endmodule

// File: rtl/aes_sub_shift_stage.sv
// Iterative SubBytes + ShiftRows stage feeding MixColumns. A state is taken
// in over valid/ready, SBOX_LANES bytes are substituted per cycle in place,
// and the row-shifted work register is held until the consumer takes it.
module aes_sub_shift_stage
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_STATE_W-1] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_STATE_W-1] out_state,
  output logic                   busy
);

  localparam int NSUB = AES_BYTES / SBOX_LANES;
  localparam int CW   = (NSUB > 1) ? $clog2(NSUB) : 1;

  sub_shift_st_e state_q, state_d;
  aes_state_t    work_q;
  aes_state_t    sub_work;
  logic [CW-1:0] cnt_q;
  logic [7:0]    sbox_in  [SBOX_LANES];
  logic [7:0]    sbox_out [SBOX_LANES];
  int            base;
  logic          last_sub;
  logic          accept;

  // First byte handled this sub-cycle. The modulo only matters when NSUB=1:
  // the 1-bit counter can read 1 after the single update, but the window
  // must stay at byte 0.
  always_comb begin
    base     = (int'(cnt_q) % NSUB) * SBOX_LANES;
    last_sub = ((int'(cnt_q) % NSUB) == NSUB - 1);
  end

  // Gather the bytes in the current window for the S-box lanes.
  always_comb begin
    for (int l = 0; l < SBOX_LANES; l++) begin
      sbox_in[l] = work_q[8*(base + l) +: 8];
    end
  end

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .plain (sbox_in[g]),
      .subst (sbox_out[g])
    );
  end

  // Write the substituted bytes back into their window, rest untouched.
  always_comb begin
    sub_work = work_q;
    for (int l = 0; l < SBOX_LANES; l++) begin
      sub_work[8*(base + l) +: 8] = sbox_out[l];
    end
  end

  // Next-state and handshake decode; outputs depend only on state_q, so no
  // input reaches an output combinationally.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ST_SUB;
      end
      ST_SUB: begin
        if (last_sub) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its inputs from before the edge, independent of block order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Work register and sub-cycle counter: load on accept, update in SUB.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the work register is plain flops, not a memory, so it takes the
    // async reset; that is what makes out_state read zero out of reset.
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      work_q <= in_state;
      cnt_q  <= '0;
    end else if (state_q == ST_SUB) begin
      work_q <= sub_work;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // ShiftRows is wiring only; it stays stable whenever work_q is held.
  assign out_state = shift_rows(work_q);

endmodule

// File: tb/tb_aes_sub_shift_stage.sv
// Bench for aes_sub_shift_stage: three instances (4, 8, 16 lanes) driven
// one at a time; expected states and latencies go into a scoreboard queue on
// accept and are popped when out_valid appears.
module tb_aes_sub_shift_stage;

  localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] ALL_00   = {16{8'h00}};
  localparam logic [127:0] ALL_52   = {16{8'h52}};
  localparam logic [127:0] ALL_63   = {16{8'h63}};

  typedef struct {
    logic [127:0] data;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic [0:127] in_state_a  [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic [0:127] out_state_a [3];
  logic         busy_a      [3];

  exp_t sb[$];
  int   n_checks;
  int   n_fails;

  aes_sub_shift_stage #(.SBOX_LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_state(in_state_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_state(out_state_a[0]),
    .busy(busy_a[0])
  );

  aes_sub_shift_stage #(.SBOX_LANES(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_state(in_state_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_state(out_state_a[1]),
    .busy(busy_a[1])
  );

  aes_sub_shift_stage #(.SBOX_LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_state(in_state_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_state(out_state_a[2]),
    .busy(busy_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Present a state to instance k; push the expectation on the accept edge.
  task automatic send(input int k, input logic [127:0] data,
                      input logic [127:0] exp, input int lat);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    in_state_a[k] = data;
    in_valid_a[k] = 1'b1;
    while (n < 20 && !ok) begin
      if (in_ready_a[k]) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check($sformatf("accept_%0d", k), 128'(ok), 128'(1));
    if (ok) begin
      sb.push_back('{data: exp, lat: lat});
      @(posedge clk);
      #1;
    end
    in_valid_a[k] = 1'b0;
  endtask

  // Count negedges from the accept edge until out_valid is seen.
  task automatic wait_valid(input int k, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(negedge clk);
      lat++;
      if (out_valid_a[k]) got = 1'b1;
    end
    check($sformatf("out_valid_seen_%0d", k), 128'(got), 128'(1));
  endtask

  // Pop and compare one result, returning the expected state.
  task automatic pop_compare(input int k, input int lat, output logic [127:0] exp_data);
    exp_t e;
    check($sformatf("sb_nonempty_%0d", k), 128'(sb.size() > 0), 128'(1));
    exp_data = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_data = e.data;
      check($sformatf("latency_%0d", k), 128'(lat), 128'(e.lat));
      check($sformatf("out_state_%0d", k), out_state_a[k], e.data);
    end
  endtask

  // Receive with out_ready high: compare, take the transfer, expect IDLE.
  task automatic receive(input int k);
    int lat;
    bit got;
    logic [127:0] exp_data;
    wait_valid(k, lat, got);
    if (got) begin
      pop_compare(k, lat, exp_data);
      @(posedge clk);
      #1;
      check($sformatf("in_ready_after_xfer_%0d", k), 128'(in_ready_a[k]), 128'(1));
      check($sformatf("out_valid_after_xfer_%0d", k), 128'(out_valid_a[k]), 128'(0));
    end
  endtask

  initial begin
    int lat;
    bit got;
    logic [127:0] held;

    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_a[k]  = 1'b0;
      in_state_a[k]  = '0;
      out_ready_a[k] = 1'b1;
    end

    // Reset state on every instance.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready_%0d", k),  128'(in_ready_a[k]),  128'(1));
      check($sformatf("rst_out_valid_%0d", k), 128'(out_valid_a[k]), 128'(0));
      check($sformatf("rst_busy_%0d", k),      128'(busy_a[k]),      128'(0));
      check($sformatf("rst_out_state_%0d", k), out_state_a[k],       ALL_00);
    end
    rst_n = 1'b1;

    // FIPS-197 round-1 vector and constant states at the default width.
    send(0, FIPS_IN, FIPS_OUT, 5);
    receive(0);
    send(0, ALL_00, ALL_63, 5);
    receive(0);
    send(0, ALL_52, ALL_00, 5);
    receive(0);

    // Backpressure: hold DONE for 10 cycles, poke in_valid, then release.
    out_ready_a[0] = 1'b0;
    send(0, FIPS_IN, FIPS_OUT, 5);
    wait_valid(0, lat, got);
    if (got) begin
      pop_compare(0, lat, held);
      for (int i = 0; i < 10; i++) begin
        if (i == 3) begin
          in_state_a[0] = ALL_52;
          in_valid_a[0] = 1'b1;
        end
        if (i == 5) in_valid_a[0] = 1'b0;
        @(negedge clk);
        check($sformatf("bp_stable_%0d", i),    out_state_a[0],        held);
        check($sformatf("bp_in_ready_%0d", i),  128'(in_ready_a[0]),   128'(0));
        check($sformatf("bp_out_valid_%0d", i), 128'(out_valid_a[0]),  128'(1));
      end
      out_ready_a[0] = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_in_ready",  128'(in_ready_a[0]),  128'(1));
      check("bp_release_out_valid", 128'(out_valid_a[0]), 128'(0));
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check($sformatf("bp_no_extra_%0d", i), 128'(out_valid_a[0] | busy_a[0]), 128'(0));
      end
    end

    // Reset during the second SUB cycle discards the block.
    send(0, FIPS_IN, FIPS_OUT, 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  128'(in_ready_a[0]),  128'(1));
    check("mid_rst_busy",      128'(busy_a[0]),      128'(0));
    check("mid_rst_out_valid", 128'(out_valid_a[0]), 128'(0));
    check("mid_rst_out_state", out_state_a[0],       ALL_00);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("mid_rst_quiet_%0d", i), 128'(out_valid_a[0]), 128'(0));
    end
    send(0, ALL_00, ALL_63, 5);
    receive(0);

    // Lane-count sweep on the same vector.
    send(1, FIPS_IN, FIPS_OUT, 3);
    receive(1);
    send(2, FIPS_IN, FIPS_OUT, 2);
    receive(2);
    send(2, ALL_52, ALL_00, 2);
    receive(2);

    check("sb_drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
